// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Main control FSM for a multicycle MIPS datapath. The FSM steps through
//   fetch, decode, execute, memory and writeback states. It drives the ALU
//   control and operand muxes, the PC and register-file write enables, and
//   the request/write strobes of a unified memory that uses a ready handshake.
//
//   The state register is the only storage. Every output is decoded
//   combinationally from the state and the current opcode/funct/zero/mem_ready.
//   While reset_n is low, all outputs read 0.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   opcode      instr[31:26] from the instruction register
//   funct       instr[5:0] from the instruction register
//   zero        ALU zero flag
//   mem_ready   memory completes the current access this cycle
//   mem_req     memory access request
//   memwrite    memory write strobe
//   irwrite     instruction register load
//   regwrite    register file write
//   pc_en       PC load (pcwrite | branch & zero)
//   iord        memory address select: 0 = PC, 1 = ALUOut
//   memtoreg    writeback data select: 1 = MDR, 0 = ALUOut
//   regdst      destination select: 1 = rd, 0 = rt
//   alusrca     ALU A select: 0 = PC, 1 = reg A
//   alusrcb     ALU B select: 00 B, 01 4, 10 signimm, 11 signimm<<2
//   pcsrc       PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   alucontrol  ALU op: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT
//   illegal_op  one-cycle pulse on an unsupported opcode or funct
//
// Optional build macro
//   IMM_LOGIC_EN  adds the andi/ori execute states (ANDIEX, ORIEX). When the
//                 macro is undefined, those opcodes are treated as illegal.
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pc_en,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ANDIEX/ORIEX always have encodings. Without IMM_LOGIC_EN, they are never
  // entered and fall into the unused-encoding recovery path.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXEC   = STATE_W'(6),
    S_ALUWB  = STATE_W'(7),
    S_BRANCH = STATE_W'(8),
    S_ADDIEX = STATE_W'(9),
    S_IWB    = STATE_W'(10),
    S_JUMP   = STATE_W'(11),
    S_ANDIEX = STATE_W'(12),
    S_ORIEX  = STATE_W'(13)
  } state_t;

  state_t state_q, state_d;

  logic       mem_req_c, memwrite_c, irwrite_c, regwrite_c;
  logic       pcwrite_c, branch_c, iord_c, memtoreg_c, regdst_c, alusrca_c;
  logic [1:0] alusrcb_c, pcsrc_c;
  logic [2:0] alucontrol_c;
  logic       illegal_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    mem_req_c    = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    regwrite_c   = 1'b0;
    pcwrite_c    = 1'b0;
    branch_c     = 1'b0;
    iord_c       = 1'b0;
    memtoreg_c   = 1'b0;
    regdst_c     = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = 2'b00;
    pcsrc_c      = 2'b00;
    alucontrol_c = 3'b000;
    illegal_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed every fetch cycle, but it is only committed
        // together with the IR load once memory completes.
        mem_req_c    = 1'b1;
        alusrcb_c    = 2'b01;
        alucontrol_c = ALU_ADD;
        irwrite_c    = mem_ready;
        pcwrite_c    = mem_ready;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut.
        alusrcb_c    = 2'b11;
        alucontrol_c = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef IMM_LOGIC_EN
          OP_ANDI:      state_d = S_ANDIEX;
          OP_ORI:       state_d = S_ORIEX;
`endif
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = ALU_ADD;
        state_d      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        state_d   = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c  = 1'b1;
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrca_c = 1'b1;
        state_d   = S_ALUWB;
        case (funct)
          6'b100000: alucontrol_c = ALU_ADD;
          6'b100010: alucontrol_c = ALU_SUB;
          6'b100100: alucontrol_c = ALU_AND;
          6'b100101: alucontrol_c = ALU_OR;
          6'b101010: alucontrol_c = ALU_SLT;
          default: begin
            // Unsupported funct: flag it and skip the register write.
            alucontrol_c = ALU_ADD;
            illegal_c    = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
      end
      S_BRANCH: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = 2'b01;
        branch_c     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = ALU_ADD;
        state_d      = S_IWB;
      end
`ifdef IMM_LOGIC_EN
      S_ANDIEX: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = ALU_AND;
        state_d      = S_IWB;
      end
      S_ORIEX: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = ALU_OR;
        state_d      = S_IWB;
      end
`endif
      S_IWB: begin
        regwrite_c = 1'b1;
      end
      S_JUMP: begin
        pcsrc_c   = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // All outputs are gated by reset_n, so an abandoned access (for example, a
  // write in flight) drops in the same cycle that reset asserts.
  assign mem_req    = reset_n & mem_req_c;
  assign memwrite   = reset_n & memwrite_c;
  assign irwrite    = reset_n & irwrite_c;
  assign regwrite   = reset_n & regwrite_c;
  assign pc_en      = reset_n & (pcwrite_c | (branch_c & zero));
  assign iord       = reset_n & iord_c;
  assign memtoreg   = reset_n & memtoreg_c;
  assign regdst     = reset_n & regdst_c;
  assign alusrca    = reset_n & alusrca_c;
  assign alusrcb    = {2{reset_n}} & alusrcb_c;
  assign pcsrc      = {2{reset_n}} & pcsrc_c;
  assign alucontrol = {3{reset_n}} & alucontrol_c;
  assign illegal_op = reset_n & illegal_c;

endmodule
